// File: rtl/memory_access_cycle.sv
// Memory stage of the RISC-V pipeline: forwards ALU results to writeback or runs
// one load/store over a req/ack data port, with alignment and timeout checking.
module memory_access_cycle #(
    parameter int XLEN           = 32,
    parameter int REG_ADDR_SIZE  = 5,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [XLEN-1:0]          ex_alu_result,
    input  logic [XLEN-1:0]          ex_store_data,
    input  logic                     ex_mem_read,
    input  logic                     ex_mem_write,
    input  logic [2:0]               ex_funct3,
    input  logic [REG_ADDR_SIZE-1:0] ex_rd,
    input  logic                     ex_reg_write,
    output logic                     dmem_req,
    output logic                     dmem_we,
    output logic [XLEN-1:0]          dmem_addr,
    output logic [XLEN-1:0]          dmem_wdata,
    output logic [3:0]               dmem_be,
    input  logic                     dmem_ack,
    input  logic [XLEN-1:0]          dmem_rdata,
    output logic                     wb_valid,
    output logic [REG_ADDR_SIZE-1:0] wb_rd,
    output logic [XLEN-1:0]          wb_data,
    output logic                     wb_reg_write,
    output logic                     misaligned,
    output logic                     bus_error
);

    typedef enum logic {
        S_IDLE,
        S_ACCESS
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } size_t;

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                   r_state;
    logic [CNT_W-1:0]         r_cnt;
    logic                     r_isLoad;
    size_t                    r_size;
    logic                     r_unsigned;
    logic [1:0]               r_offset;
    logic [REG_ADDR_SIZE-1:0] r_rd;
    logic                     r_regWrite;

    logic                     w_isMem;
    size_t                    w_size;
    logic                     w_unsigned;
    logic [1:0]               w_offset;
    logic                     w_misaligned;
    logic [3:0]               w_storeBe;
    logic [XLEN-1:0]          w_storeWdata;
    logic [7:0]               w_loadByte;
    logic [15:0]              w_loadHalf;
    logic [XLEN-1:0]          w_loadData;

    assign in_ready = (r_state == S_IDLE);

    // Decode the incoming access; unsupported funct3 encodings fall through to word.
    always_comb begin
        w_isMem    = ex_mem_read | ex_mem_write;
        w_offset   = ex_alu_result[1:0];
        w_unsigned = (ex_funct3 == 3'b100) || (ex_funct3 == 3'b101);
        case (ex_funct3)
            3'b000, 3'b100: w_size = SZ_BYTE;
            3'b001, 3'b101: w_size = SZ_HALF;
            default:        w_size = SZ_WORD;
        endcase
        w_misaligned = w_isMem &&
                       (((w_size == SZ_HALF) && w_offset[0]) ||
                        ((w_size == SZ_WORD) && (w_offset != 2'b00)));
        case (w_size)
            SZ_BYTE: begin
                w_storeBe    = 4'b0001 << w_offset;
                w_storeWdata = {(XLEN/8){ex_store_data[7:0]}};
            end
            SZ_HALF: begin
                w_storeBe    = w_offset[1] ? 4'b1100 : 4'b0011;
                w_storeWdata = {(XLEN/16){ex_store_data[15:0]}};
            end
            default: begin
                w_storeBe    = 4'b1111;
                w_storeWdata = ex_store_data;
            end
        endcase
    end

    // Lane-select the returned word with the latched offset, then extend.
    always_comb begin
        w_loadByte = dmem_rdata[{r_offset, 3'b000} +: 8];
        w_loadHalf = dmem_rdata[{r_offset[1], 4'b0000} +: 16];
        case (r_size)
            SZ_BYTE: w_loadData = r_unsigned ? {{(XLEN-8){1'b0}}, w_loadByte}
                                             : {{(XLEN-8){w_loadByte[7]}}, w_loadByte};
            SZ_HALF: w_loadData = r_unsigned ? {{(XLEN-16){1'b0}}, w_loadHalf}
                                             : {{(XLEN-16){w_loadHalf[15]}}, w_loadHalf};
            default: w_loadData = dmem_rdata;
        endcase
    end

    // Single FSM: IDLE accepts work, ACCESS holds the bus request until ack or timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_isLoad     <= 1'b0;
            r_size       <= SZ_BYTE;
            r_unsigned   <= 1'b0;
            r_offset     <= 2'b00;
            r_rd         <= '0;
            r_regWrite   <= 1'b0;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_wdata   <= '0;
            dmem_be      <= 4'b0000;
            wb_valid     <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            wb_reg_write <= 1'b0;
            misaligned   <= 1'b0;
            bus_error    <= 1'b0;
        end else begin
            wb_valid   <= 1'b0;
            misaligned <= 1'b0;
            bus_error  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        wb_rd <= ex_rd;
                        if (!w_isMem) begin
                            wb_valid     <= 1'b1;
                            wb_data      <= ex_alu_result;
                            wb_reg_write <= ex_reg_write && (ex_rd != '0);
                        end else if (w_misaligned) begin
                            wb_valid     <= 1'b1;
                            wb_data      <= '0;
                            wb_reg_write <= 1'b0;
                            misaligned   <= 1'b1;
                        end else begin
                            r_state    <= S_ACCESS;
                            r_cnt      <= '0;
                            r_isLoad   <= ex_mem_read;
                            r_size     <= w_size;
                            r_unsigned <= w_unsigned;
                            r_offset   <= w_offset;
                            r_rd       <= ex_rd;
                            r_regWrite <= ex_reg_write && (ex_rd != '0);
                            dmem_req   <= 1'b1;
                            dmem_we    <= ~ex_mem_read;
                            dmem_addr  <= {ex_alu_result[XLEN-1:2], 2'b00};
                            dmem_be    <= ex_mem_read ? 4'b1111 : w_storeBe;
                            dmem_wdata <= ex_mem_read ? '0 : w_storeWdata;
                        end
                    end
                end
                S_ACCESS: begin
                    if (dmem_ack) begin
                        r_state      <= S_IDLE;
                        dmem_req     <= 1'b0;
                        dmem_we      <= 1'b0;
                        wb_valid     <= 1'b1;
                        wb_rd        <= r_rd;
                        wb_data      <= r_isLoad ? w_loadData : '0;
                        wb_reg_write <= r_regWrite & r_isLoad;
                    end else if (r_cnt == CNT_LIMIT) begin
                        r_state      <= S_IDLE;
                        dmem_req     <= 1'b0;
                        dmem_we      <= 1'b0;
                        wb_valid     <= 1'b1;
                        wb_rd        <= r_rd;
                        wb_data      <= '0;
                        wb_reg_write <= 1'b0;
                        bus_error    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_access_cycle.sv
// Scoreboard bench for memory_access_cycle: a driver issues directed and random
// transactions, a memory responder answers requests, a monitor checks writebacks.
module tb_memory_access_cycle;

    localparam int XLEN    = 32;
    localparam int RAS     = 5;
    localparam int TIMEOUT = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] ex_alu_result;
    logic [XLEN-1:0] ex_store_data;
    logic            ex_mem_read;
    logic            ex_mem_write;
    logic [2:0]      ex_funct3;
    logic [RAS-1:0]  ex_rd;
    logic            ex_reg_write;
    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic [3:0]      dmem_be;
    logic            dmem_ack;
    logic [XLEN-1:0] dmem_rdata;
    logic            wb_valid;
    logic [RAS-1:0]  wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            wb_reg_write;
    logic            misaligned;
    logic            bus_error;

    memory_access_cycle #(
        .XLEN(XLEN),
        .REG_ADDR_SIZE(RAS),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_funct3(ex_funct3), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_reg_write(wb_reg_write), .misaligned(misaligned), .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [RAS-1:0] rd;
        logic [31:0]    data;
        bit             checkData;
        bit             checkRd;
        logic           regWrite;
        logic           mis;
        logic           berr;
        int             cycle;
    } wb_exp_t;

    typedef struct {
        int          delay;
        logic [31:0] rdata;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          dur;
    } req_exp_t;

    wb_exp_t  wbQ[$];
    req_exp_t reqQ[$];
    int       checks = 0;
    int       errors = 0;
    int       cycleCount = 0;

    wb_exp_t  monExp;
    req_exp_t respCur;
    bit       respActive = 0;
    bit       respBogus = 0;
    int       respCycles = 0;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cycleCount);
        end
    endtask

    // Issue one instruction, predict its outcome from the architectural rules,
    // and for bus accesses wait until its writeback has been retired.
    task automatic applyStimulus(input logic rdI, input logic wrI, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] sd,
                                 input logic [RAS-1:0] rd, input logic rw,
                                 input int delay, input logic [31:0] rdata);
        int size, off, n, budget;
        bit isMem, uns, mis, timedOut;
        logic [31:0] v;
        wb_exp_t w;
        req_exp_t q;
        checkOutput("in_ready_before_issue", 32'(in_ready), 32'd1);
        in_valid      = 1'b1;
        ex_mem_read   = rdI;
        ex_mem_write  = wrI;
        ex_funct3     = f3;
        ex_alu_result = addr;
        ex_store_data = sd;
        ex_rd         = rd;
        ex_reg_write  = rw;
        @(posedge clk);
        #1;
        n = cycleCount;
        in_valid      = 1'b0;
        ex_alu_result = $urandom;
        ex_store_data = $urandom;

        isMem = rdI || wrI;
        case (f3)
            3'b000, 3'b100: size = 1;
            3'b001, 3'b101: size = 2;
            default:        size = 4;
        endcase
        uns      = (f3 == 3'b100) || (f3 == 3'b101);
        off      = int'(addr % 4);
        mis      = isMem && (off % size != 0);
        timedOut = isMem && !mis && (delay == 0 || delay > TIMEOUT);

        w.rd      = rd;
        w.checkRd = !mis && !timedOut;
        w.mis     = mis;
        w.berr    = timedOut;
        if (!isMem) begin
            w.data      = addr;
            w.checkData = 1;
            w.regWrite  = rw && (rd != 0);
            w.cycle     = n;
        end else if (mis) begin
            w.data      = 0;
            w.checkData = 0;
            w.regWrite  = 0;
            w.cycle     = n;
        end else begin
            w.cycle     = n + (timedOut ? TIMEOUT : delay);
            w.checkData = !timedOut;
            w.regWrite  = !timedOut && rdI && rw && (rd != 0);
            if (!rdI) begin
                w.data = 0;
            end else begin
                v = rdata >> (8 * off);
                if (size == 1) begin
                    v = v & 32'hFF;
                    if (!uns && v >= 128) v = v - 256;
                end else if (size == 2) begin
                    v = v & 32'hFFFF;
                    if (!uns && v >= 32768) v = v - 65536;
                end
                w.data = v;
            end
            q.delay = delay;
            q.rdata = rdata;
            q.addr  = addr - off;
            q.we    = !rdI;
            q.dur   = timedOut ? TIMEOUT : delay;
            q.wdata = 0;
            if (rdI) begin
                q.be = 4'hF;
            end else begin
                q.be = 4'(((1 << size) - 1) << off);
                for (int i = 0; i < 4; i++) q.wdata[8*i +: 8] = sd[8*(i % size) +: 8];
            end
            reqQ.push_back(q);
        end
        wbQ.push_back(w);

        if (isMem && !mis) begin
            budget = 0;
            while (wbQ.size() != 0 && budget < 40) begin
                @(posedge clk);
                #1;
                budget++;
            end
            checkOutput("writeback_arrived", wbQ.size(), 0);
            if (wbQ.size() != 0) begin
                wbQ.delete();
                reqQ.delete();
            end
        end
    endtask

    // Memory responder: checks each request cycle and acks after the chosen delay.
    always @(negedge clk) begin
        if (rst) begin
            respActive = 0;
            dmem_ack   = 1'b0;
            dmem_rdata = '0;
        end else if (dmem_req) begin
            if (!respActive) begin
                respActive = 1;
                respCycles = 0;
                if (reqQ.size() == 0) begin
                    respBogus = 1;
                    checkOutput("unexpected_dmem_req", 32'(dmem_req), 32'd0);
                end else begin
                    respBogus = 0;
                    respCur   = reqQ.pop_front();
                end
            end
            respCycles++;
            checkOutput("in_ready_busy", 32'(in_ready), 32'd0);
            if (!respBogus) begin
                checkOutput("dmem_addr", dmem_addr, respCur.addr);
                checkOutput("dmem_we", 32'(dmem_we), 32'(respCur.we));
                checkOutput("dmem_be", 32'(dmem_be), 32'(respCur.be));
                if (respCur.we) checkOutput("dmem_wdata", dmem_wdata, respCur.wdata);
            end
            if (!respBogus && respCur.delay == respCycles) begin
                dmem_ack   = 1'b1;
                dmem_rdata = respCur.rdata;
            end else begin
                dmem_ack   = 1'b0;
                dmem_rdata = $urandom;
            end
        end else begin
            if (respActive && !respBogus) checkOutput("dmem_req_cycles", respCycles, respCur.dur);
            respActive = 0;
            dmem_ack   = ($urandom_range(0, 3) == 0);
            dmem_rdata = $urandom;
        end
    end

    // Writeback monitor: every wb_valid pulse must match the oldest prediction.
    always @(negedge clk) begin
        if (!rst) begin
            if (wb_valid) begin
                if (wbQ.size() == 0) begin
                    checkOutput("unexpected_wb_valid", 32'(wb_valid), 32'd0);
                end else begin
                    monExp = wbQ.pop_front();
                    checkOutput("wb_latency", cycleCount, monExp.cycle);
                    checkOutput("wb_reg_write", 32'(wb_reg_write), 32'(monExp.regWrite));
                    checkOutput("misaligned", 32'(misaligned), 32'(monExp.mis));
                    checkOutput("bus_error", 32'(bus_error), 32'(monExp.berr));
                    if (monExp.checkRd) checkOutput("wb_rd", 32'(wb_rd), 32'(monExp.rd));
                    if (monExp.checkData) checkOutput("wb_data", wb_data, monExp.data);
                end
            end else if (misaligned || bus_error) begin
                checkOutput("flag_without_wb", 32'({misaligned, bus_error}), 32'd0);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [1:0]     op;
        logic [31:0]    addr;
        logic [RAS-1:0] rd;
        rst           = 1'b0;
        in_valid      = 1'b0;
        ex_alu_result = '0;
        ex_store_data = '0;
        ex_mem_read   = 1'b0;
        ex_mem_write  = 1'b0;
        ex_funct3     = 3'b000;
        ex_rd         = '0;
        ex_reg_write  = 1'b0;
        #1 rst = 1'b1;
        #2;
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_dmem_req", 32'(dmem_req), 32'd0);
        checkOutput("reset_wb_valid", 32'(wb_valid), 32'd0);
        checkOutput("reset_flags", 32'({misaligned, bus_error, wb_reg_write}), 32'd0);
        checkOutput("reset_dmem_be", 32'(dmem_be), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] directed: ALU pass-through x3");
        repeat (3) applyStimulus(1'b0, 1'b0, 3'b010, 32'h0000_1234, 32'h0, 5'd5, 1'b1, 1, 32'h0);
        $display("[TB] directed: LB, SH, misaligned LW, timeout");
        applyStimulus(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 5'd7, 1'b1, 3, 32'h80FF_FF7F);
        applyStimulus(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 5'd9, 1'b1, 1, 32'h0);
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0, 5'd4, 1'b1, 1, 32'h0);
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 5'd6, 1'b1, 0, 32'h0);
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 5'd6, 1'b1, 4, 32'h1357_9BDF);

        $display("[TB] directed: reset during access");
        in_valid      = 1'b1;
        ex_mem_read   = 1'b1;
        ex_mem_write  = 1'b0;
        ex_funct3     = 3'b010;
        ex_alu_result = 32'h0000_0040;
        ex_rd         = 5'd3;
        ex_reg_write  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        reqQ.push_back('{delay: 0, rdata: 32'h0, addr: 32'h40, we: 1'b0, be: 4'hF, wdata: 32'h0, dur: TIMEOUT});
        @(posedge clk);
        #1;
        checkOutput("req_before_reset", 32'(dmem_req), 32'd1);
        #1 rst = 1'b1;
        #1;
        checkOutput("req_drop_on_reset", 32'(dmem_req), 32'd0);
        checkOutput("in_ready_in_reset", 32'(in_ready), 32'd1);
        checkOutput("wb_valid_in_reset", 32'(wb_valid), 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("in_ready_after_reset", 32'(in_ready), 32'd1);
        checkOutput("req_queue_after_reset", reqQ.size(), 0);
        applyStimulus(1'b1, 1'b0, 3'b101, 32'h0000_0002, 32'h0, 5'd8, 1'b1, 2, 32'h8001_0000);

        $display("[TB] random transactions");
        for (int i = 0; i < 250; i++) begin
            op   = 2'($urandom_range(0, 3));
            addr = $urandom;
            if ($urandom_range(0, 1) == 0) addr[1:0] = 2'b00;
            rd   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            applyStimulus(op == 2'd1 || op == 2'd3, op[1], 3'($urandom_range(0, 7)), addr,
                          $urandom, rd, ($urandom_range(0, 3) != 0),
                          $urandom_range(0, 6), $urandom);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end

        repeat (5) @(posedge clk);
        #1;
        checkOutput("wb_queue_drained", wbQ.size(), 0);
        checkOutput("req_queue_drained", reqQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_access_cycle.md
Name: memory_access_cycle

Overview:
- Memory stage of the RISC-V pipeline; consumes the execute stage's ALU result and either forwards it to writeback or uses it as the address of a load/store.
- Drives a req/ack data-memory port, produces byte enables and store lane replication, and sign- or zero-extends load data.
- Stalls upstream via in_ready while a memory transaction is outstanding; flags misaligned accesses and bus timeouts.

Parameters:
- XLEN, 32, data/address width
- REG_ADDR_SIZE, 5, register index width
- TIMEOUT_CYCLES, 255, maximum ACCESS cycles without dmem_ack before bus error (≥1)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  execute result valid
- in_ready  out  1  stage can accept; high only in IDLE
- ex_alu_result  in  XLEN  ALU result; the address for memory ops
- ex_store_data  in  XLEN  rs2 value for stores
- ex_mem_read  in  1  load
- ex_mem_write  in  1  store
- ex_funct3  in  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
- ex_rd  in  REG_ADDR_SIZE  destination register
- ex_reg_write  in  1  instruction writes rd
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write
- dmem_addr  out  XLEN  word-aligned address {addr[XLEN-1:2],2'b00}
- dmem_wdata  out  XLEN  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_ack  in  1  request complete; rdata valid same cycle
- dmem_rdata  in  XLEN  read data
- wb_valid  out  1  one-cycle writeback pulse
- wb_rd  out  REG_ADDR_SIZE  destination register
- wb_data  out  XLEN  result
- wb_reg_write  out  1  register-file write enable
- misaligned  out  1  one-cycle pulse, misaligned access dropped
- bus_error  out  1  one-cycle pulse, timeout

Behaviour:
- Reset (async): state IDLE, timeout counter 0, all outputs 0 except in_ready = 1. Reset during ACCESS drops dmem_req immediately and discards the transaction; no wb_valid is produced.
- FSM states IDLE and ACCESS. All outputs except in_ready are registered.
- IDLE, handshake (in_valid & in_ready):
  - No memory op: wb_valid = 1 next cycle with wb_data = ex_alu_result. Latency is 1 and a new acceptance is possible every cycle.
  - Memory op, aligned: enter ACCESS and assert dmem_req next cycle.
  - Memory op, misaligned (H/HU with addr[0] = 1; W with addr[1:0] ≠ 0): no request. Next cycle, misaligned = 1 and wb_valid = 1 with wb_reg_write = 0.
- Both ex_mem_read and ex_mem_write set: treated as a load.
- Unsupported funct3 (011, 110, 111): treated as W.
- ACCESS:
  - dmem_req, dmem_we, dmem_addr, dmem_wdata and dmem_be are held stable until dmem_ack.
  - Loads: dmem_be = 1111.
  - SB: dmem_be = 0001 << addr[1:0], wdata = byte replicated ×4.
  - SH: dmem_be = 0011 or 1100 by addr[1], wdata = halfword replicated ×2.
  - SW: dmem_be = 1111.
- On dmem_ack in ACCESS:
  - dmem_req drops next cycle and the FSM returns to IDLE.
  - wb_valid pulses with wb_reg_write = ex_reg_write & load & (rd ≠ 0).
  - Load data: select the byte/halfword by addr[1:0], then sign-extend (B, H) or zero-extend (BU, HU).
  - Stores: wb_data = 0.
  - Total latency = cycles to ack + 1.
- Timeout: the counter increments every ACCESS cycle without ack. When it reaches TIMEOUT_CYCLES, dmem_req drops and the FSM returns to IDLE; bus_error and wb_valid pulse with wb_reg_write = 0. If ack arrives in the same cycle the limit is reached, ack wins.
- rd = 0 always forces wb_reg_write = 0.
- dmem_ack while in IDLE is ignored.
- in_valid while in ACCESS: not accepted; upstream holds its inputs.

Test Plan:
- ALU pass-through: in_valid with ex_alu_result = 0x0000_1234, rd = 5, reg_write = 1 on three consecutive cycles -> wb_valid on three consecutive cycles, wb_data = 0x1234, wb_rd = 5, in_ready stays 1.
- LB with addr 0x103, ack after 3 cycles, rdata 0x80FF_FF7F -> dmem_addr = 0x100, dmem_be = 1111, in_ready low for 3 cycles, wb_data = 0xFFFF_FF80.
- SH with addr 0x202, store_data 0x0000_ABCD, ack after 1 cycle -> dmem_we = 1, dmem_be = 1100, dmem_wdata = 0xABCD_ABCD, wb_reg_write = 0.
- LW with addr 0x101 -> misaligned pulses, no dmem_req, wb_valid with wb_reg_write = 0.
- TIMEOUT_CYCLES = 4 and ack never arrives -> dmem_req high for exactly 4 cycles, then bus_error pulses; a repeat run with ack on the 4th cycle completes normally with no bus_error.
- rst asserted mid-ACCESS -> dmem_req drops asynchronously, no wb_valid, in_ready = 1 after release; LHU addr 0x2, rdata 0x8001_0000 -> wb_data = 0x0000_8001.
